btn_request_latch: RTL and testbench
====================================

Name: btn_request_latch

Overview:
- Input-side counterpart of the elevator display path; the display consumes the floor_btn/up/down request vectors, and this block produces them.
- Debounces raw car and hall buttons, edge-detects presses and holds pending requests until the control FSM clears them on service.
- Outputs direction summaries (req_above/req_below/req_here) for the FSM.
- Sits between board button inputs and the FSM/Display.

Parameters:
- NFLOORS, 8, number of floors; the vectors are NFLOORS wide and the floor index is 3 bits.
- TICK_DIV, 100_000, clk cycles per debounce sample tick (1 ms at 100 MHz).
- DEB_TICKS, 20, consecutive differing samples needed to accept a new level.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- floor_raw  in  8  raw car buttons, active-high, asynchronous to clk
- up_raw  in  8  raw hall-up buttons
- down_raw  in  8  raw hall-down buttons
- cur_floor  in  3  current car floor, 0-based
- clr_floor  in  1  pulse: clear floor_btn[cur_floor]
- clr_up  in  1  pulse: clear up[cur_floor]
- clr_down  in  1  pulse: clear down[cur_floor]
- floor_btn  out  8  latched car requests
- up  out  8  latched hall-up requests
- down  out  8  latched hall-down requests
- req_above  out  1  any request at a floor > cur_floor
- req_below  out  1  any request at a floor < cur_floor
- req_here  out  1  any request at cur_floor
- new_req  out  1  one-cycle pulse when any request bit goes 0->1

Behaviour:
- Reset: all outputs 0, tick counter 0, every debounce counter 0, every stable level 0.
- Synchroniser: each raw bit passes through a 2-flop synchroniser before debounce.
- Tick: a free-running counter counts 0..TICK_DIV-1; tick=1 for one cycle when it wraps.
- Debounce, per button, evaluated only on tick:
  - If sync != stable, cnt++.
  - If sync == stable, cnt=0.
  - When cnt reaches DEB_TICKS-1 while the levels still differ, stable<=sync and cnt<=0.
- Press: a rising edge of stable gives press=1 for exactly one clk cycle. Release events are ignored.
- Latch: on press, the matching request bit is set on the next clk edge.
- Latency: a raw level held from cycle t sets the request no later than t+2+DEB_TICKS*TICK_DIV+TICK_DIV+1 cycles.
- Invalid hall buttons are tied to 0 and ignored: up[NFLOORS-1] (no up at the top floor) and down[0] (no down at the bottom floor).
- Clear: clr_* clears only the bit at index cur_floor, and has effect in the same cycle it is asserted (the bit is 0 after that edge).
- Clear and press on the same bit in the same cycle: clear wins and the bit stays 0 (the car is already serving that floor).
- Clear and press on different bits in the same cycle: both take effect.
- Summaries, combinational from registered vectors and cur_floor:
  - req_here = floor_btn|up|down at cur_floor.
  - req_above/req_below = OR of the same over higher/lower indices.
  - cur_floor=7 forces req_above=0; cur_floor=0 forces req_below=0.
- new_req: registered. It is 1 the cycle after any request bit transitions 0->1; multiple simultaneous sets give a single pulse.
- Held button: produces one press only. Re-press requires a debounced release first.
- rst mid-debounce: discards the partial count, and a held button re-qualifies from zero.

Optional Feature:
- Macro: BTN_CANCEL_EN.
- Defined: a press on an already-set floor_btn bit clears it (cancel), except when index == cur_floor. In that case the bit stays set. new_req does not pulse on a cancel. Hall buttons are unaffected.
- Undefined: a press on a set bit has no effect.

Decomposition:
- Package elevator_pkg:
  - constants NFLOORS=8 and FLOOR_W=3.
  - typedef floor_t (logic [FLOOR_W-1:0]) and req_vec_t (logic [NFLOORS-1:0]).
  - The default TICK_DIV/DEB_TICKS values.
- Sub-module btn_debounce: one raw bit in, tick input, press pulse out; holds the synchroniser, counter and stable level. 24 instances are generated in btn_request_latch.
- Tick generator and request registers stay in btn_request_latch.

Test Plan:
All scenarios use TICK_DIV=4, DEB_TICKS=3.
- Hold floor_raw[5]=1 for 40 cycles, cur_floor=2 -> floor_btn=8'h20 within 2+12+4+1 cycles; new_req pulses once; req_above=1, req_below=0.
- floor_raw[3] glitches high for 6 cycles, then low -> floor_btn stays 8'h00, no new_req.
- up_raw[7]=1 and down_raw[0]=1 held -> up=8'h00, down=8'h00.
- up[4] latched, cur_floor=4, clr_up pulse coincident with a fresh up_raw[4] press -> up[4]=0 after that edge; req_here=0.
- Hold floor_raw[1]; assert rst at the midpoint of debounce for 1 cycle -> all outputs 0; floor_btn[1] sets a full debounce period after rst deasserts.
- With BTN_CANCEL_EN: floor_btn[6]=1, cur_floor=0, second debounced press of floor_raw[6] -> floor_btn[6]=0, no new_req. Without the macro -> stays 1.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared elevator constants and types used by the button request path.
// Default debounce timing targets a 100 MHz clock with 1 ms samples.
package elevator_pkg;

  localparam int NFLOORS       = 8;
  localparam int FLOOR_W       = 3;
  localparam int TICK_DIV_DEF  = 100_000;
  localparam int DEB_TICKS_DEF = 20;

  typedef logic [FLOOR_W-1:0] floor_t;
  typedef logic [NFLOORS-1:0] req_vec_t;

  // No hall-up button exists at the top floor, and no hall-down button at the bottom floor.
  localparam req_vec_t UP_VALID   = ~(req_vec_t'(1) << (NFLOORS - 1));
  localparam req_vec_t DOWN_VALID = ~req_vec_t'(1);

  function automatic req_vec_t floor_mask(input floor_t f);
    floor_mask = req_vec_t'(1) << f;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, tick-sampled debounce counter, stable level
// and a single-cycle press pulse on each debounced rising edge.
module btn_debounce
  import elevator_pkg::*;
#(
  parameter int DEB_TICKS = DEB_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic tick,
  output logic press
);

  localparam int CW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_TICKS - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (tick) begin
      if (sync2_q == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
    end
  end

  assign press = stable_q & ~prev_q;

endmodule

// File: rtl/btn_request_latch.sv
// Debounced car/hall button request latch with direction summaries for the FSM.
// Optional BTN_CANCEL_EN: re-pressing a latched car button (not at cur_floor) cancels it.
module btn_request_latch
  import elevator_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int DEB_TICKS = DEB_TICKS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NFLOORS-1:0] floor_raw,
  input  logic [NFLOORS-1:0] up_raw,
  input  logic [NFLOORS-1:0] down_raw,
  input  logic [FLOOR_W-1:0] cur_floor,
  input  logic               clr_floor,
  input  logic               clr_up,
  input  logic               clr_down,
  output logic [NFLOORS-1:0] floor_btn,
  output logic [NFLOORS-1:0] up,
  output logic [NFLOORS-1:0] down,
  output logic               req_above,
  output logic               req_below,
  output logic               req_here,
  output logic               new_req
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt_q;
  logic [TW-1:0] tick_cnt_d;
  logic          tick;

  req_vec_t floor_press;
  req_vec_t up_press;
  req_vec_t down_press;

  req_vec_t floor_q, floor_d;
  req_vec_t up_q, up_d;
  req_vec_t down_q, down_d;
  logic     new_req_q, new_req_d;
  req_vec_t any_req;
  req_vec_t here_mask;

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  for (genvar i = 0; i < NFLOORS; i++) begin : g_btn
    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_floor (
      .clk  (clk),
      .rst  (rst),
      .raw  (floor_raw[i]),
      .tick (tick),
      .press(floor_press[i])
    );
    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_up (
      .clk  (clk),
      .rst  (rst),
      .raw  (up_raw[i]),
      .tick (tick),
      .press(up_press[i])
    );
    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_down (
      .clk  (clk),
      .rst  (rst),
      .raw  (down_raw[i]),
      .tick (tick),
      .press(down_press[i])
    );
  end

  // Clears are applied last so a coincident press on the served bit loses.
  always_comb begin
    here_mask = floor_mask(cur_floor);
    floor_d   = floor_q | floor_press;
`ifdef BTN_CANCEL_EN
    floor_d   = floor_d & ~(floor_q & floor_press & ~here_mask);
`endif
    up_d      = (up_q | up_press) & UP_VALID;
    down_d    = (down_q | down_press) & DOWN_VALID;
    if (clr_floor) floor_d = floor_d & ~here_mask;
    if (clr_up)    up_d    = up_d & ~here_mask;
    if (clr_down)  down_d  = down_d & ~here_mask;
    new_req_d = |((floor_d & ~floor_q) | (up_d & ~up_q) | (down_d & ~down_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      floor_q    <= '0;
      up_q       <= '0;
      down_q     <= '0;
      new_req_q  <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      floor_q    <= floor_d;
      up_q       <= up_d;
      down_q     <= down_d;
      new_req_q  <= new_req_d;
    end
  end

  always_comb begin
    any_req   = floor_q | up_q | down_q;
    req_here  = any_req[cur_floor];
    req_above = 1'b0;
    req_below = 1'b0;
    for (int unsigned i = 0; i < NFLOORS; i++) begin
      if (i > int'(unsigned'(cur_floor))) req_above = req_above | any_req[i];
      if (i < int'(unsigned'(cur_floor))) req_below = req_below | any_req[i];
    end
  end

  assign floor_btn = floor_q;
  assign up        = up_q;
  assign down      = down_q;
  assign new_req   = new_req_q;

endmodule

// File: tb/tb_btn_request_latch.sv
// Scenario bench for btn_request_latch with short debounce timing (TICK_DIV=4, DEB_TICKS=3).
module tb_btn_request_latch;

  localparam int TD  = 4;
  localparam int DT  = 3;
  localparam int LAT = 2 + DT * TD + TD + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] floor_raw, up_raw, down_raw;
  logic [2:0] cur_floor;
  logic       clr_floor, clr_up, clr_down;
  logic [7:0] floor_btn, up, down;
  logic       req_above, req_below, req_here, new_req;

  int vectors     = 0;
  int miscompares = 0;
  int nr_pulses   = 0;
  int cyc         = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  btn_request_latch #(.TICK_DIV(TD), .DEB_TICKS(DT)) dut (
    .clk      (clk),
    .rst      (rst),
    .floor_raw(floor_raw),
    .up_raw   (up_raw),
    .down_raw (down_raw),
    .cur_floor(cur_floor),
    .clr_floor(clr_floor),
    .clr_up   (clr_up),
    .clr_down (clr_down),
    .floor_btn(floor_btn),
    .up       (up),
    .down     (down),
    .req_above(req_above),
    .req_below(req_below),
    .req_here (req_here),
    .new_req  (new_req)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (new_req === 1'b1) nr_pulses <= nr_pulses + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected self-termination");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; floor_raw = '0; up_raw = '0; down_raw = '0; cur_floor = '0;
    clr_floor = 1'b0; clr_up = 1'b0; clr_down = 1'b0;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    idle(3);
    exp_v = exp_q.pop_front(); vectors++;
    if (floor_btn !== exp_v) begin miscompares++; $display("FAIL reset_floor_btn: got %h expected %h", floor_btn, exp_v); end
    exp_v = exp_q.pop_front(); vectors++;
    if (up !== exp_v) begin miscompares++; $display("FAIL reset_up: got %h expected %h", up, exp_v); end
    exp_v = exp_q.pop_front(); vectors++;
    if (down !== exp_v) begin miscompares++; $display("FAIL reset_down: got %h expected %h", down, exp_v); end
    exp_v = exp_q.pop_front(); vectors++;
    if ({4'b0, req_above, req_below, req_here, new_req} !== exp_v) begin
      miscompares++; $display("FAIL reset_flags: got %b expected %b", {req_above, req_below, req_here, new_req}, exp_v[3:0]);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_press_hold;
    int base;
    cur_floor = 3'd2;
    base = nr_pulses;
    exp_q.push_back(8'h20);
    floor_raw[5] = 1'b1;
    for (int k = 0; k < LAT && floor_btn !== 8'h20; k++) @(negedge clk);
    exp_v = exp_q.pop_front(); vectors++;
    if (floor_btn !== exp_v) begin miscompares++; $display("FAIL press_latency: got %h expected %h", floor_btn, exp_v); end
    idle(25);
    exp_q.push_back(8'd1); exp_q.push_back(8'b100);
    exp_v = exp_q.pop_front(); vectors++;
    if (8'(nr_pulses - base) !== exp_v) begin miscompares++; $display("FAIL press_new_req_count: got %0d expected %0d", nr_pulses - base, exp_v); end
    exp_v = exp_q.pop_front(); vectors++;
    if ({5'b0, req_above, req_below, req_here} !== exp_v) begin
      miscompares++; $display("FAIL press_summary: got %b expected %b", {req_above, req_below, req_here}, exp_v[2:0]);
    end
    floor_raw[5] = 1'b0;
    exp_q.push_back(8'h20);
    idle(25);
    exp_v = exp_q.pop_front(); vectors++;
    if (floor_btn !== exp_v) begin miscompares++; $display("FAIL release_ignored: got %h expected %h", floor_btn, exp_v); end
    cur_floor = 3'd5; clr_floor = 1'b1;
    exp_q.push_back(8'h00);
    @(negedge clk);
    clr_floor = 1'b0;
    exp_v = exp_q.pop_front(); vectors++;
    if (floor_btn !== exp_v) begin miscompares++; $display("FAIL clear_floor: got %h expected %h", floor_btn, exp_v); end
  endtask

  task automatic test_glitch;
    int base;
    base = nr_pulses;
    exp_q.push_back(8'h00); exp_q.push_back(8'd0);
    floor_raw[3] = 1'b1;
    idle(6);
    floor_raw[3] = 1'b0;
    idle(30);
    exp_v = exp_q.pop_front(); vectors++;
    if (floor_btn !== exp_v) begin miscompares++; $display("FAIL glitch_floor_btn: got %h expected %h", floor_btn, exp_v); end
    exp_v = exp_q.pop_front(); vectors++;
    if (8'(nr_pulses - base) !== exp_v) begin miscompares++; $display("FAIL glitch_new_req: got %0d expected %0d", nr_pulses - base, exp_v); end
  endtask

  task automatic test_invalid_hall;
    int base;
    cur_floor = 3'd3;
    base = nr_pulses;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'd0);
    up_raw[7] = 1'b1; down_raw[0] = 1'b1;
    idle(30);
    exp_v = exp_q.pop_front(); vectors++;
    if (up !== exp_v) begin miscompares++; $display("FAIL invalid_up: got %h expected %h", up, exp_v); end
    exp_v = exp_q.pop_front(); vectors++;
    if (down !== exp_v) begin miscompares++; $display("FAIL invalid_down: got %h expected %h", down, exp_v); end
    exp_v = exp_q.pop_front(); vectors++;
    if (8'(nr_pulses - base) !== exp_v) begin miscompares++; $display("FAIL invalid_new_req: got %0d expected %0d", nr_pulses - base, exp_v); end
    up_raw[7] = 1'b0; down_raw[0] = 1'b0;
    idle(25);
  endtask

  task automatic test_clear_press;
    int base, start, lat;
    cur_floor = 3'd4;
    start = cyc;
    base = nr_pulses;
    exp_q.push_back(8'h10); exp_q.push_back(8'd1);
    up_raw[4] = 1'b1;
    lat = 0;
    while (up[4] !== 1'b1 && lat < LAT) begin @(negedge clk); lat++; end
    exp_v = exp_q.pop_front(); vectors++;
    if (up !== exp_v) begin miscompares++; $display("FAIL first_up_press: got %h expected %h", up, exp_v); end
    idle(2);
    exp_v = exp_q.pop_front(); vectors++;
    if ({7'b0, req_here} !== exp_v) begin miscompares++; $display("FAIL first_up_here: got %b expected %b", req_here, exp_v[0]); end
    up_raw[4] = 1'b0;
    idle(25);
    for (int k = 0; k < TD && ((cyc - start) % TD) != 0; k++) @(negedge clk);
    if (lat < 1) lat = 1;
    base = nr_pulses;
    exp_q.push_back(8'h00); exp_q.push_back(8'd0); exp_q.push_back(8'h00); exp_q.push_back(8'd0);
    up_raw[4] = 1'b1;
    idle(lat - 1);
    clr_up = 1'b1;
    @(negedge clk);
    clr_up = 1'b0;
    exp_v = exp_q.pop_front(); vectors++;
    if (up !== exp_v) begin miscompares++; $display("FAIL clear_beats_press: got %h expected %h", up, exp_v); end
    exp_v = exp_q.pop_front(); vectors++;
    if ({7'b0, req_here} !== exp_v) begin miscompares++; $display("FAIL clear_req_here: got %b expected %b", req_here, exp_v[0]); end
    idle(10);
    exp_v = exp_q.pop_front(); vectors++;
    if (up !== exp_v) begin miscompares++; $display("FAIL held_no_repress: got %h expected %h", up, exp_v); end
    exp_v = exp_q.pop_front(); vectors++;
    if (8'(nr_pulses - base) !== exp_v) begin miscompares++; $display("FAIL clear_new_req: got %0d expected %0d", nr_pulses - base, exp_v); end
    up_raw[4] = 1'b0;
    idle(25);
  endtask

  task automatic test_multi;
    int base;
    cur_floor = 3'd3;
    base = nr_pulses;
    exp_q.push_back(8'h01); exp_q.push_back(8'h40); exp_q.push_back(8'd1); exp_q.push_back(8'b110);
    exp_q.push_back(8'b010); exp_q.push_back(8'b101);
    floor_raw[0] = 1'b1; up_raw[6] = 1'b1;
    for (int k = 0; k < LAT && floor_btn[0] !== 1'b1; k++) @(negedge clk);
    idle(3);
    exp_v = exp_q.pop_front(); vectors++;
    if (floor_btn !== exp_v) begin miscompares++; $display("FAIL multi_floor: got %h expected %h", floor_btn, exp_v); end
    exp_v = exp_q.pop_front(); vectors++;
    if (up !== exp_v) begin miscompares++; $display("FAIL multi_up: got %h expected %h", up, exp_v); end
    exp_v = exp_q.pop_front(); vectors++;
    if (8'(nr_pulses - base) !== exp_v) begin miscompares++; $display("FAIL multi_single_pulse: got %0d expected %0d", nr_pulses - base, exp_v); end
    exp_v = exp_q.pop_front(); vectors++;
    if ({5'b0, req_above, req_below, req_here} !== exp_v) begin
      miscompares++; $display("FAIL multi_summary_f3: got %b expected %b", {req_above, req_below, req_here}, exp_v[2:0]);
    end
    cur_floor = 3'd7;
    #1;
    exp_v = exp_q.pop_front(); vectors++;
    if ({5'b0, req_above, req_below, req_here} !== exp_v) begin
      miscompares++; $display("FAIL summary_top: got %b expected %b", {req_above, req_below, req_here}, exp_v[2:0]);
    end
    cur_floor = 3'd0;
    #1;
    exp_v = exp_q.pop_front(); vectors++;
    if ({5'b0, req_above, req_below, req_here} !== exp_v) begin
      miscompares++; $display("FAIL summary_bottom: got %b expected %b", {req_above, req_below, req_here}, exp_v[2:0]);
    end
    floor_raw[0] = 1'b0; up_raw[6] = 1'b0;
    idle(25);
  endtask

  task automatic test_rst_mid;
    exp_q.push_back(8'h04);
    down_raw[2] = 1'b1;
    for (int k = 0; k < LAT && down[2] !== 1'b1; k++) @(negedge clk);
    down_raw[2] = 1'b0;
    idle(25);
    exp_v = exp_q.pop_front(); vectors++;
    if (down !== exp_v) begin miscompares++; $display("FAIL pre_rst_down: got %h expected %h", down, exp_v); end
    floor_raw[1] = 1'b1;
    idle(8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h02);
    exp_v = exp_q.pop_front(); vectors++;
    if (floor_btn !== exp_v) begin miscompares++; $display("FAIL rst_mid_floor: got %h expected %h", floor_btn, exp_v); end
    exp_v = exp_q.pop_front(); vectors++;
    if (up !== exp_v) begin miscompares++; $display("FAIL rst_mid_up: got %h expected %h", up, exp_v); end
    exp_v = exp_q.pop_front(); vectors++;
    if (down !== exp_v) begin miscompares++; $display("FAIL rst_mid_down: got %h expected %h", down, exp_v); end
    exp_v = exp_q.pop_front(); vectors++;
    if ({4'b0, req_above, req_below, req_here, new_req} !== exp_v) begin
      miscompares++; $display("FAIL rst_mid_flags: got %b expected %b", {req_above, req_below, req_here, new_req}, exp_v[3:0]);
    end
    idle(11);
    exp_v = exp_q.pop_front(); vectors++;
    if (floor_btn !== exp_v) begin miscompares++; $display("FAIL rst_requalify_early: got %h expected %h", floor_btn, exp_v); end
    for (int k = 11; k < LAT && floor_btn !== 8'h02; k++) @(negedge clk);
    exp_v = exp_q.pop_front(); vectors++;
    if (floor_btn !== exp_v) begin miscompares++; $display("FAIL rst_requalify: got %h expected %h", floor_btn, exp_v); end
    floor_raw[1] = 1'b0;
    idle(25);
  endtask

  task automatic test_cancel;
    int base;
    cur_floor = 3'd0;
    exp_q.push_back(8'h42);
    floor_raw[6] = 1'b1;
    for (int k = 0; k < LAT && floor_btn[6] !== 1'b1; k++) @(negedge clk);
    floor_raw[6] = 1'b0;
    idle(25);
    exp_v = exp_q.pop_front(); vectors++;
    if (floor_btn !== exp_v) begin miscompares++; $display("FAIL cancel_setup: got %h expected %h", floor_btn, exp_v); end
    base = nr_pulses;
`ifdef BTN_CANCEL_EN
    exp_q.push_back(8'h02);
`else
    exp_q.push_back(8'h42);
`endif
    exp_q.push_back(8'd0);
    floor_raw[6] = 1'b1;
    idle(LAT + 2);
    exp_v = exp_q.pop_front(); vectors++;
    if (floor_btn !== exp_v) begin miscompares++; $display("FAIL second_press: got %h expected %h", floor_btn, exp_v); end
    exp_v = exp_q.pop_front(); vectors++;
    if (8'(nr_pulses - base) !== exp_v) begin miscompares++; $display("FAIL second_press_new_req: got %0d expected %0d", nr_pulses - base, exp_v); end
    floor_raw[6] = 1'b0;
    idle(25);
    cur_floor = 3'd1;
    exp_q.push_back(8'h02);
    floor_raw[1] = 1'b1;
    idle(LAT + 2);
    exp_v = exp_q.pop_front(); vectors++;
    if (floor_btn[1] !== exp_v[1]) begin miscompares++; $display("FAIL repress_at_cur_floor: got %b expected %b", floor_btn[1], exp_v[1]); end
    floor_raw[1] = 1'b0;
    idle(5);
  endtask

  initial begin
    test_reset();
    test_press_hold();
    test_glitch();
    test_invalid_hall();
    test_clear_press();
    test_multi();
    test_rst_mid();
    test_cancel();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
